// File: rtl/tone_seq_pkg.sv
// Shared types and defaults for the tone sequencer.
// Holds the FSM state enum, the step record and the default sample divider.
package tone_seq_pkg;

    localparam int DEF_CLK_DIV = 2083;
    localparam int SEQ_DUR_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } state_t;

    typedef struct packed {
        logic [29:0]          delta;
        logic [SEQ_DUR_W-1:0] dur;
    } step_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate strobe divider: counts 0..DIV-1 and pulses o_tick on DIV-1.
// Ports: i_clk, i_rst_n (async active-low), o_tick (one-cycle strobe).
module sample_tick_gen #(
    parameter int DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // The strobe is registered one count early so it is high
    // exactly while the counter holds DIV-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            r_tick <= (r_cnt == PRE);
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/tone_sequencer.sv
// Plays a programmed (delta_angle, duration) step list into sin_gen.
// Ports: cfg_* step-memory write, seq_len/loop_en/start/stop control,
// busy/step_idx/done status, get_next_sample strobe, delta_angle out.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int NUM_STEPS = 16,
    parameter int STEP_W    = 4,
    parameter int DUR_W     = SEQ_DUR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [STEP_W-1:0] cfg_addr,
    input  logic [29:0]       cfg_delta,
    input  logic [DUR_W-1:0]  cfg_dur,
    input  logic [STEP_W:0]   seq_len,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic [STEP_W-1:0] step_idx,
    output logic              done,
    output logic              get_next_sample,
    output logic [29:0]       delta_angle
);

    state_t            r_state;
    step_t             r_mem [NUM_STEPS];
    step_t             r_rd;
    logic [STEP_W-1:0] r_idx;
    logic [29:0]       r_delta;
    logic [DUR_W-1:0]  r_dur;
    logic [STEP_W:0]   r_len;
    logic              r_loop;
    logic              r_busy;
    logic              r_done;

    logic              w_tick;
    logic              w_start_ok;
    logic              w_step_end;
    logic              w_last;
    logic [STEP_W-1:0] w_next_idx;
    logic [STEP_W-1:0] w_rd_addr;

    sample_tick_gen #(
        .DIV (CLK_DIV)
    ) u_tick (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_tick  (w_tick)
    );

    // stop beats a coincident start; out-of-range lengths are dropped
    assign w_start_ok = start && !stop && (seq_len != '0) &&
                        (seq_len <= (STEP_W+1)'(NUM_STEPS));
    assign w_step_end = (r_state == PLAY) && w_tick &&
                        (r_dur == DUR_W'(1));
    assign w_last     = ({1'b0, r_idx} == (r_len - 1'b1));
    assign w_next_idx = w_last ? '0 : r_idx + 1'b1;

    // Read address runs one cycle ahead so LOAD sees the step's data
    always_comb begin
        w_rd_addr = r_idx;
        if (r_state == IDLE) begin
            w_rd_addr = '0;
        end else if (w_step_end) begin
            w_rd_addr = w_next_idx;
        end
    end

    // Step memory: not reset; read returns pre-write contents
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            r_mem[cfg_addr] <= '{delta: cfg_delta, dur: cfg_dur};
        end
        r_rd <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_delta <= '0;
            r_dur   <= '0;
            r_len   <= '0;
            r_loop  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_len   <= seq_len;
                        r_loop  <= loop_en;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        r_delta <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_delta <= r_rd.delta;
                        // zero-length step still plays one sample
                        r_dur   <= (r_rd.dur == '0) ? DUR_W'(1) : r_rd.dur;
                        r_state <= PLAY;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        r_delta <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_tick) begin
                        if (r_dur == DUR_W'(1)) begin
                            if (!w_last || r_loop) begin
                                r_idx   <= w_next_idx;
                                r_state <= LOAD;
                            end else begin
                                r_done  <= 1'b1;
                                r_delta <= '0;
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_dur <= r_dur - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign step_idx        = r_idx;
    assign done            = r_done;
    assign get_next_sample = w_tick;
    assign delta_angle     = r_delta;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer (CLK_DIV=8).
// Expected outputs come from a per-cycle schedule built from the step list.
module tb_tone_sequencer;

    localparam int DIV = 8;
    localparam int N   = 512;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [29:0] cfg_delta;
    logic [15:0] cfg_dur;
    logic [4:0]  seq_len;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic        busy;
    logic [3:0]  step_idx;
    logic        done;
    logic        get_next_sample;
    logic [29:0] delta_angle;

    tone_sequencer #(
        .CLK_DIV   (DIV),
        .NUM_STEPS (16),
        .STEP_W    (4),
        .DUR_W     (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_delta       (cfg_delta),
        .cfg_dur         (cfg_dur),
        .seq_len         (seq_len),
        .loop_en         (loop_en),
        .start           (start),
        .stop            (stop),
        .busy            (busy),
        .step_idx        (step_idx),
        .done            (done),
        .get_next_sample (get_next_sample),
        .delta_angle     (delta_angle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc, ts, stop_at, restart_at;
    bit sched_on;
    int len_m;
    bit lp_m;

    logic [29:0] pd   [16];
    logic [15:0] pdur [16];

    bit          wr_valid;
    int          wr_rel;
    int          wr_addr;
    logic [29:0] wr_delta;
    logic [15:0] wr_dur;

    bit          e_busy  [N];
    bit          e_done  [N];
    logic [29:0] e_delta [N];
    logic [3:0]  e_idx   [N];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %h expected %h",
                   tag, cyc, obs, exp);
        end
    endtask

    // memory contents seen by a read issued in relative cycle rc
    function automatic logic [29:0] m_delta(input int k, input int rc);
        if (wr_valid && wr_addr == k && wr_rel < rc) return wr_delta;
        return pd[k];
    endfunction

    function automatic int m_dur(input int k, input int rc);
        int d;
        d = (wr_valid && wr_addr == k && wr_rel < rc) ? int'(wr_dur)
                                                      : int'(pdur[k]);
        return (d == 0) ? 1 : d;
    endfunction

    // Timeline: LOAD cycle, then PLAY until the dur-th strobe, then
    // either the next LOAD or a done cycle.
    task automatic build();
        int r, s, k, left;
        logic [29:0] cur;
        for (int i = 0; i < N; i++) begin
            e_busy[i]  = 1'b0;
            e_done[i]  = 1'b0;
            e_delta[i] = '0;
            e_idx[i]   = '0;
        end
        k = 0;
        cur = '0;
        r = 1;
        while (r < N) begin
            e_busy[r]  = 1'b1;
            e_delta[r] = cur;
            e_idx[r]   = 4'(k);
            cur  = m_delta(k, r - 1);
            left = m_dur(k, r - 1);
            s = r + 1;
            while (s < N) begin
                e_busy[s]  = 1'b1;
                e_delta[s] = cur;
                e_idx[s]   = 4'(k);
                if ((ts + s) % DIV == DIV - 1) begin
                    left--;
                    if (left == 0) break;
                end
                s++;
            end
            if (s >= N - 1) break;
            if (k < len_m - 1) k++;
            else if (lp_m) k = 0;
            else begin
                e_done[s + 1] = 1'b1;
                break;
            end
            r = s + 1;
        end
    endtask

    task automatic cyc_step();
        int r;
        bit eb, ed;
        logic [29:0] edl;
        logic [3:0] ei;
        @(posedge clk);
        #1;
        start  = 1'b0;
        stop   = 1'b0;
        cfg_we = 1'b0;
        cyc++;
        eb = 1'b0;
        ed = 1'b0;
        edl = '0;
        ei = '0;
        if (sched_on) begin
            r = cyc - ts;
            if (r > 0 && r < N && r <= stop_at) begin
                eb  = e_busy[r];
                ed  = e_done[r];
                edl = e_delta[r];
                ei  = e_idx[r];
            end
        end
        chk("tick", 32'(get_next_sample), 32'(cyc % DIV == DIV - 1));
        chk("busy", 32'(busy), 32'(eb));
        chk("delta", 32'(delta_angle), 32'(edl));
        chk("done", 32'(done), 32'(ed));
        if (eb) chk("idx", 32'(step_idx), 32'(ei));
    endtask

    task automatic run(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            cyc_step();
            r = cyc - ts;
            if (wr_valid && r == wr_rel) begin
                cfg_we    = 1'b1;
                cfg_addr  = 4'(wr_addr);
                cfg_delta = wr_delta;
                cfg_dur   = wr_dur;
            end
            if (r == stop_at) stop = 1'b1;
            if (r == restart_at) start = 1'b1;
            if (r == 1) begin
                seq_len = 5'($urandom_range(1, 16));
                loop_en = 1'($urandom);
            end
        end
    endtask

    task automatic clear_plan();
        stop_at    = 1 << 30;
        restart_at = -1;
        wr_valid   = 1'b0;
    endtask

    task automatic wr_step(input int a, input logic [29:0] d,
                           input logic [15:0] du);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(a);
        cfg_delta = d;
        cfg_dur   = du;
        pd[a]     = d;
        pdur[a]   = du;
        cyc_step();
    endtask

    task automatic go(input int len, input bit lp);
        seq_len = 5'(len);
        loop_en = lp;
        start   = 1'b1;
        ts      = cyc;
        len_m   = len;
        lp_m    = lp;
        build();
        sched_on = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_delta"}, 32'(delta_angle), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_idx"}, 32'(step_idx), 32'd0);
        chk({tag, "_tick"}, 32'(get_next_sample), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_delta = '0;
        cfg_dur = '0;
        seq_len = '0;
        loop_en = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        sched_on = 1'b0;
        cyc = 0;
        ts = 0;
        len_m = 1;
        lp_m = 1'b0;
        clear_plan();

        // reset, then idle: strobe every 8 cycles, first at cycle 7
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        cyc = 0;
        run(100);

        // two steps, no loop; ignored start and late seq_len change
        wr_step(0, 30'h0100_0000, 16'd3);
        wr_step(1, 30'h0200_0000, 16'd2);
        clear_plan();
        restart_at = 10;
        go(2, 1'b0);
        run(80);

        // looping, stopped mid-play
        clear_plan();
        stop_at = 90;
        go(2, 1'b1);
        run(110);

        // zero-length step, then ignored starts
        wr_step(2, 30'h0ABC_0000, 16'd0);
        wr_step(3, 30'h0123_4567, 16'd1);
        sched_on = 1'b0;
        clear_plan();
        cfg_addr = 4'd0;
        wr_step(0, 30'h0055_0000, 16'd0);
        go(1, 1'b0);
        run(30);
        sched_on = 1'b0;
        seq_len = 5'd0;
        start = 1'b1;
        run(12);
        seq_len = 5'd17;
        start = 1'b1;
        run(12);
        seq_len = 5'd2;
        start = 1'b1;
        stop = 1'b1;
        run(12);

        // rewrite step0 while it plays: old value until the next pass
        wr_step(0, 30'h0100_0000, 16'd3);
        clear_plan();
        wr_valid = 1'b1;
        wr_rel   = 5;
        wr_addr  = 0;
        wr_delta = 30'h0300_0000;
        wr_dur   = 16'd1;
        stop_at  = 140;
        go(2, 1'b1);
        run(150);
        pd[0]   = wr_delta;
        pdur[0] = wr_dur;

        // asynchronous reset mid-PLAY
        clear_plan();
        go(2, 1'b1);
        run(30);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        sched_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("arst_hold");
        rst_n = 1'b1;
        cyc = 0;
        clear_plan();
        run(24);

        // randomized programs
        for (int it = 0; it < 8; it++) begin
            int len;
            bit lp;
            sched_on = 1'b0;
            len = $urandom_range(1, 4);
            lp  = 1'($urandom);
            for (int a = 0; a < len; a++) begin
                wr_step(a, 30'($urandom), 16'($urandom_range(0, 3)));
            end
            run($urandom_range(0, 7));
            clear_plan();
            restart_at = 1;
            if (lp) stop_at = $urandom_range(30, 120);
            go(len, lp);
            run(140);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Controller that plays a programmed note sequence through the sine generator / delta-sigma DAC chain.
- Generates the sample-rate strobe (get_next_sample) and programs delta_angle, one step at a time.
- Holds a small step memory of (delta_angle, duration) pairs.
- Sits between the control/UI logic and the sin_gen input pins.

Parameters:
- CLK_DIV, 2083, system clocks per audio sample (100 MHz / 48 kHz); must be >= 4.
- NUM_STEPS, 16, depth of the step memory.
- STEP_W, 4, log2(NUM_STEPS).
- DUR_W, 16, width of a step duration, counted in samples.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write strobe for the step memory
- cfg_addr  in  STEP_W  step index to write
- cfg_delta  in  30  delta_angle for that step (same format as sin_gen: 0 to 1.999..)
- cfg_dur  in  DUR_W  step length in samples
- seq_len  in  STEP_W+1  number of steps to play (1..NUM_STEPS)
- loop_en  in  1  1 = wrap to step 0 after the last step
- start  in  1  one-cycle start pulse
- stop  in  1  one-cycle stop pulse
- busy  out  1  high in LOAD and PLAY
- step_idx  out  STEP_W  index of the current step
- done  out  1  one-cycle pulse when a non-looping sequence ends
- get_next_sample  out  1  sample strobe to sin_gen
- delta_angle  out  30  phase increment to sin_gen

Behaviour:
- Reset values: all outputs 0; state IDLE; tick counter 0; step memory contents undefined (not reset).
- Tick generator:
  - Counter runs 0..CLK_DIV-1 in every state, including IDLE.
  - get_next_sample is high for exactly one cycle when the counter equals CLK_DIV-1, then the counter wraps to 0.
- Step memory:
  - Synchronous write on cfg_we; synchronous read with 1-cycle latency.
  - Writes are allowed while busy. A write to the current step takes effect only when that step is next loaded.
- States:
  - IDLE: delta_angle=0, busy=0. On start with seq_len in 1..NUM_STEPS: capture seq_len and loop_en, set step_idx=0, issue read of step 0, go to LOAD. start with seq_len=0 or seq_len>NUM_STEPS is ignored.
  - LOAD (1 cycle): latch read data into delta_angle and the duration counter. A duration of 0 is treated as 1. Go to PLAY.
  - PLAY:
    - Each get_next_sample decrements the duration counter.
    - On the strobe that brings it to 0, the step completes.
    - If step_idx < seq_len-1: step_idx+1, read, go to LOAD.
    - Else if loop_en: step_idx=0, read, go to LOAD.
    - Else: pulse done, delta_angle=0, go to IDLE.
- Latency:
  - start at cycle t → delta_angle valid at t+2.
  - Step change: the new delta_angle is valid 2 cycles after the completing strobe, always before the next strobe because CLK_DIV >= 4.
- Simultaneous events and control rules:
  - stop in LOAD or PLAY → IDLE next cycle, delta_angle=0, no done pulse.
  - stop and start in the same cycle: stop wins.
  - start while busy is ignored.
  - seq_len and loop_en are sampled only at start; later changes have no effect until the next start.
- Reset mid-operation: immediate return to reset values. The tick phase restarts at counter 0.

Decomposition:
- Package tone_seq_pkg holds:
  - state enum (IDLE, LOAD, PLAY);
  - step_t struct {delta[29:0], dur[DUR_W-1:0]};
  - default CLK_DIV constant.
- One sub-module, sample_tick_gen: parameterised divider that produces the get_next_sample strobe. It is reused wherever a sample-rate strobe is needed.

Test Plan (CLK_DIV=8):
- Reset then idle 100 cycles → get_next_sample pulses every 8 cycles, first at cycle 7 after reset release; delta_angle=0; busy=0.
- Program step0=(0x0100_0000, 3) and step1=(0x0200_0000, 2); seq_len=2, loop_en=0; start → delta 0x0100_0000 for 3 strobes, then 0x0200_0000 for 2 strobes, then done=1 for one cycle, delta_angle=0, busy=0.
- Same program with loop_en=1 → step_idx sequence 0,0,0,1,1,0,0,0,… and done never asserts; stop → IDLE next cycle, delta_angle=0.
- Step with dur=0 → lasts exactly 1 strobe; start with seq_len=0 → stays IDLE, busy=0.
- start and stop in the same cycle from IDLE → remains IDLE. Rewrite step0 during PLAY of step0 → old value holds until step0 is reloaded on the next loop pass.
- Assert rst_n low mid-PLAY → all outputs 0 asynchronously; after release, the tick counter restarts from 0.
